// File: rtl/dffram_byte_sequencer.sv
// Byte request/response front end for port A of the 32x8 2R1W DFF RAM tile.
// Each byte access becomes two nibble accesses. Read nibbles are reassembled into one response byte.
`timescale 1ns/1ps
module dffram_byte_sequencer #(
  parameter int RD_LATENCY = 0,
  parameter int NUM_WORDS  = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_addrhi,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_wdata,
  output logic       ram_lohi,
  output logic       ram_wen,
  input  logic [3:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_RSP
  } state_t;

  localparam logic       LAST_WAIT   = (RD_LATENCY != 0);
  localparam logic [5:0] NUM_WORDS_W = 6'(NUM_WORDS);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_err;
  logic       r_wait;
  logic       w_accept;
  logic       w_err;
  logic       w_sample;

  assign w_accept = req_valid && (r_state == S_IDLE);
  // A 6-bit compare lets NUM_WORDS reach 32 without the bound wrapping.
  assign w_err    = ({1'b0, cfg_addrhi, req_addr} >= NUM_WORDS_W);
  assign w_sample = (r_wait == LAST_WAIT);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output and the next state get a default first, so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_wen   = 1'b0;
    ram_lohi  = 1'b0;
    ram_wdata = 4'h0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_write) begin
            w_next = w_err ? S_IDLE : S_WR_LO;
          end else begin
            w_next = w_err ? S_RSP : S_RD_LO;
          end
        end
      end
      S_WR_LO: begin
        ram_wen   = 1'b1;
        ram_lohi  = 1'b1;
        ram_wdata = r_wdata[3:0];
        w_next    = S_WR_HI;
      end
      S_WR_HI: begin
        ram_wen   = 1'b1;
        ram_wdata = r_wdata[7:4];
        w_next    = S_IDLE;
      end
      S_RD_LO: begin
        if (w_sample) w_next = S_RD_HI;
      end
      S_RD_HI: begin
        ram_lohi = 1'b1;
        if (w_sample) w_next = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address and lo/hi stay stable through each sample cycle.
  // The buffered RAM applies its lo/hi mux after the read buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 4'h0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_err   <= 1'b0;
      r_wait  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        if (!req_write) begin
          r_err   <= w_err;
          r_rdata <= 8'h00;
        end
      end
      if (r_state == S_RD_LO || r_state == S_RD_HI) begin
        if (w_sample) begin
          r_wait <= 1'b0;
          if (r_state == S_RD_LO) begin
            r_rdata[3:0] <= ram_rdata;
          end else begin
            r_rdata[7:4] <= ram_rdata;
          end
        end else begin
          r_wait <= 1'b1;
        end
      end
    end
  end

  assign ram_addr  = r_addr;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dffram_byte_sequencer.sv
// Self-checking bench: lane 0 runs an unbuffered RAM model (RD_LATENCY=0), lane 1 a buffered one (RD_LATENCY=1).
// Stimulus pushes expectations into queues, and per-lane monitors pop and compare them.
`timescale 1ns/1ps
module tb_dffram_byte_sequencer;

  localparam int NUM_WORDS = 18;

  typedef struct packed {
    logic        err;
    logic [7:0]  data;
    logic [31:0] due;
  } rsp_exp_t;

  typedef struct packed {
    logic       lohi;
    logic [3:0] addr;
    logic [3:0] nib;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = g;

    logic       rst = 1'b0;
    logic       cfg_addrhi, req_valid, req_ready, req_write;
    logic       rsp_valid, rsp_ready, rsp_err, ram_lohi, ram_wen;
    logic [3:0] req_addr, ram_addr, ram_wdata, ram_rdata;
    logic [7:0] req_wdata, rsp_rdata;

    dffram_byte_sequencer #(.RD_LATENCY(LAT), .NUM_WORDS(NUM_WORDS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_addrhi(cfg_addrhi),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_lohi  (ram_lohi),
      .ram_wen   (ram_wen),
      .ram_rdata (ram_rdata)
    );

    // RAM port A: write lohi=1 -> bits[3:0], read lohi=1 -> bits[7:4].
    logic [7:0] init_img [32];
    logic [7:0] mem [32];
    logic [7:0] rbuf;
    logic [7:0] word;
    logic       cfg_lat;
    logic [4:0] ram_idx;
    bit         loaded = 1'b0;

    always @(posedge rst) cfg_lat <= cfg_addrhi;
    assign ram_idx = {cfg_lat, ram_addr};

    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_img[i];
        loaded <= 1'b1;
      end else if (ram_wen) begin
        if (ram_lohi) mem[ram_idx][3:0] <= ram_wdata;
        else          mem[ram_idx][7:4] <= ram_wdata;
      end
      rbuf <= mem[ram_idx];
    end

    assign word      = (LAT == 1) ? rbuf : mem[ram_idx];
    assign ram_rdata = ram_lohi ? word[7:4] : word[3:0];

    // Reference model and scoreboard state.
    logic [7:0] model [32];
    rsp_exp_t   rsp_q [$];
    wr_exp_t    wr_q  [$];
    int         n_reads = 0;
    int         n_rsps  = 0;
    int         bp_req  = 0;
    bit         armed   = 1'b0;

    function automatic string nm(input string s);
      return $sformatf("lane%0d_%s", g, s);
    endfunction

    // Monitor: checks RAM write pulses and responses, and drives rsp_ready.
    initial begin
      rsp_exp_t cur;
      wr_exp_t  w;
      bit       seen;
      int       stall;
      cur       = '0;
      seen      = 1'b0;
      stall     = 0;
      rsp_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (rst || !armed) begin
          seen      = 1'b0;
          stall     = 0;
          rsp_ready = 1'b0;
        end else begin
          if (ram_wen) begin
            if (wr_q.size() == 0) begin
              check(nm("wen_unexpected"), 32'(wr_q.size()), 32'd1);
            end else begin
              w = wr_q.pop_front();
              check(nm("wr_lohi"), 32'(ram_lohi), 32'(w.lohi));
              check(nm("wr_addr"), 32'(ram_addr), 32'(w.addr));
              check(nm("wr_nibble"), 32'(ram_wdata), 32'(w.nib));
            end
          end
          if (rsp_valid) begin
            check(nm("req_ready_busy"), 32'(req_ready), 32'd0);
            if (!seen) begin
              if (rsp_q.size() == 0) begin
                check(nm("rsp_unexpected"), 32'(rsp_q.size()), 32'd1);
              end else begin
                cur   = rsp_q.pop_front();
                seen  = 1'b1;
                stall = bp_req;
                n_rsps++;
                check(nm("rsp_latency"), cyc, cur.due);
                check(nm("rsp_rdata"), 32'(rsp_rdata), 32'(cur.data));
                check(nm("rsp_err"), 32'(rsp_err), 32'(cur.err));
              end
            end else begin
              check(nm("rsp_hold_rdata"), 32'(rsp_rdata), 32'(cur.data));
              check(nm("rsp_hold_err"), 32'(rsp_err), 32'(cur.err));
            end
            if (stall > 0) begin
              rsp_ready = 1'b0;
              stall--;
            end else begin
              rsp_ready = ($urandom_range(0, 2) != 0);
            end
            if (rsp_ready) seen = 1'b0;
          end else begin
            rsp_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    end

    task automatic do_reset(input logic cfg);
      @(negedge clk);
      req_valid  = 1'b0;
      cfg_addrhi = cfg;
      rst        = 1'b1;
      #1;
      check(nm("rst_req_ready"), 32'(req_ready), 32'd1);
      check(nm("rst_rsp_valid"), 32'(rsp_valid), 32'd0);
      check(nm("rst_rsp_rdata"), 32'(rsp_rdata), 32'd0);
      check(nm("rst_rsp_err"), 32'(rsp_err), 32'd0);
      check(nm("rst_ram_wen"), 32'(ram_wen), 32'd0);
      check(nm("rst_ram_addr"), 32'(ram_addr), 32'd0);
      check(nm("rst_ram_wdata"), 32'(ram_wdata), 32'd0);
      check(nm("rst_ram_lohi"), 32'(ram_lohi), 32'd0);
      @(negedge clk);
      rst = 1'b0;
    endtask

    task automatic send(input logic wr, input logic [3:0] addr, input logic [7:0] data);
      int       n;
      logic [4:0] idx;
      logic     err;
      rsp_exp_t e;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      while (!req_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!req_ready) begin
        check(nm("req_accept_timeout"), 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
      idx = {cfg_addrhi, addr};
      err = (32'(idx) >= NUM_WORDS);
      if (wr) begin
        if (!err) begin
          model[idx] = data;
          wr_q.push_back('{lohi: 1'b1, addr: addr, nib: data[3:0]});
          wr_q.push_back('{lohi: 1'b0, addr: addr, nib: data[7:4]});
        end
      end else begin
        e.err  = err;
        e.data = err ? 8'h00 : model[idx];
        e.due  = cyc + (err ? 1 : ((LAT == 0) ? 3 : 5));
        rsp_q.push_back(e);
        n_reads++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 4'($urandom);
      req_wdata = 8'($urandom);
    endtask

    task automatic random_ops(input int n);
      for (int i = 0; i < n; i++) begin
        send(1'($urandom_range(0, 1)),
             4'((i % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
             8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
        @(negedge clk);
        n++;
      end
      repeat (8) @(negedge clk);
      check(nm("rsp_q_empty"), 32'(rsp_q.size()), 32'd0);
      check(nm("wr_q_empty"), 32'(wr_q.size()), 32'd0);
      check(nm("rsp_count"), 32'(n_rsps), 32'(n_reads));
    endtask

    initial begin
      cfg_addrhi = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 4'h0;
      req_wdata  = 8'h00;
      for (int i = 0; i < 32; i++) begin
        init_img[i] = 8'($urandom);
        model[i]    = init_img[i];
      end
      do_reset(1'b0);
      armed = 1'b1;

      // Reset during WR_HI aborts the write at once.
      send(1'b1, 4'h3, 8'hA5);
      @(posedge clk);
      #1;
      check(nm("wen_in_wr_hi"), 32'(ram_wen), 32'd1);
      rst = 1'b1;
      #1;
      check(nm("wen_async_reset"), 32'(ram_wen), 32'd0);
      check(nm("ready_async_reset"), 32'(req_ready), 32'd1);
      wr_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check(nm("ready_after_release"), 32'(req_ready), 32'd1);

      // Write then read back the same byte.
      send(1'b1, 4'h3, 8'hA5);
      send(1'b0, 4'h3, 8'h00);

      // Hold the response for 4 cycles while a write waits behind it.
      bp_req = 4;
      send(1'b0, 4'h3, 8'h00);
      send(1'b1, 4'h3, 8'h5A);
      bp_req = 0;
      send(1'b0, 4'h3, 8'h00);

      // Back-to-back writes, then ordered reads.
      for (int i = 0; i < 4; i++) send(1'b1, 4'(i), 8'(8'h11 * (i + 1)));
      for (int i = 0; i < 4; i++) send(1'b0, 4'(i), 8'h00);

      random_ops(40);
      drain();

      // Upper half: word 18 is unpopulated, word 17 is valid.
      do_reset(1'b1);
      send(1'b1, 4'h2, 8'h3C);
      send(1'b0, 4'h2, 8'h00);
      send(1'b0, 4'h1, 8'h00);
      random_ops(30);
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1]) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1])) check("run_timeout", 32'(done[0] & done[1]), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
